// File: rtl/count_slot_scheduler_pkg.sv
// Shared types and the round-robin pick function for the count slot scheduler.
package count_sched_pkg;

  localparam int unsigned MAX_REQ = 32;
  localparam int unsigned MAX_IDW = 5;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  // First set request after ptr, wrapping modulo nreq; ptr itself is searched last.
  function automatic logic [MAX_IDW-1:0] rr_next(input logic [MAX_IDW-1:0] ptr,
                                                 input logic [MAX_REQ-1:0] req,
                                                 input int unsigned        nreq);
    logic [MAX_IDW-1:0] win;
    int unsigned        idx;
    win = '0;
    for (int unsigned i = MAX_REQ; i >= 1; i--) begin
      if (i <= nreq) begin
        idx = (32'(ptr) + i) % nreq;
        if (req[idx[MAX_IDW-1:0]]) win = MAX_IDW'(idx);
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/count_slot_scheduler_if.sv
// Request/grant bundle between requesters and the shared counter.
interface count_slot_scheduler_if #(
  parameter int unsigned N    = 4,
  parameter int unsigned NREQ = 4
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] limit_i;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic [N-1:0]      count;
  logic              done;
  logic [IDW-1:0]    done_id;

  modport master (output req, limit_i, input grant, busy, count, done, done_id);
  modport slave  (input req, limit_i, output grant, busy, count, done, done_id);
endinterface

// File: rtl/count_slot_scheduler_rr_arbiter.sv
// Combinational round-robin picker over NREQ request lines.
module rr_arbiter
  import count_sched_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    valid,
  output logic [$clog2(NREQ)-1:0] win_idx
);
  localparam int unsigned IDW = $clog2(NREQ);

  assign valid   = |req;
  assign win_idx = IDW'(rr_next(MAX_IDW'(ptr), MAX_REQ'(req), NREQ));
endmodule

// File: rtl/count_slot_scheduler.sv
// Round-robin shared modulo counter: grants one requester, counts 0..limit, pulses done.
module count_slot_scheduler
  import count_sched_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned NREQ = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  count_slot_scheduler_if.slave bus
);
  localparam int unsigned IDW = $clog2(NREQ);

  state_t          state_q, state_d;
  logic [N-1:0]    count_q, count_d;
  logic [N-1:0]    lim_q, lim_d;
  logic [IDW-1:0]  own_q, own_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [IDW-1:0]  done_id_q, done_id_d;

  logic            arb_valid;
  logic [IDW-1:0]  arb_win;
  logic [N-1:0]    lim_arr [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_lim
    assign lim_arr[k] = bus.limit_i[k*N +: N];
  end

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (bus.req),
    .ptr     (ptr_q),
    .valid   (arb_valid),
    .win_idx (arb_win)
  );

  // Next-state and output decode
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    lim_d     = lim_q;
    own_d     = own_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d = ST_RUN;
          grant_d = NREQ'(1) << arb_win;
          busy_d  = 1'b1;
          count_d = '0;
          lim_d   = lim_arr[arb_win];
          own_d   = arb_win;
          ptr_d   = arb_win;
        end
      end
      ST_RUN: begin
        // Abort wins over completion so a dropped request never sees done
        if (!bus.req[own_q]) begin
          state_d = ST_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          count_d = '0;
        end else if (count_q == lim_q) begin
          state_d   = ST_IDLE;
          grant_d   = '0;
          busy_d    = 1'b0;
          count_d   = '0;
          done_d    = 1'b1;
          done_id_d = own_q;
        end else begin
          count_d = count_q + N'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      lim_q     <= '0;
      own_q     <= '0;
      ptr_q     <= IDW'(NREQ - 1);
      grant_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      lim_q     <= lim_d;
      own_q     <= own_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.busy    = busy_q;
  assign bus.count   = count_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
endmodule

// File: tb/tb_count_slot_scheduler.sv
// Directed bench for count_slot_scheduler with N=4, NREQ=4.
module tb_count_slot_scheduler;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  count_slot_scheduler_if #(.N(4), .NREQ(4)) bus ();

  count_slot_scheduler #(.N(4), .NREQ(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lim(input int k, input logic [3:0] v);
    bus.limit_i[k*4 +: 4] = v;
  endtask

  task automatic do_reset();
    bus.req = '0;
    #2 rst_n = 1'b0;
    step();
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_grant"}, 32'(bus.grant), 32'h0);
    check({tag, "_busy"},  32'(bus.busy),  32'h0);
    check({tag, "_count"}, 32'(bus.count), 32'h0);
  endtask

  task automatic check_done(input string tag, input int id);
    check({tag, "_done"},    32'(bus.done),    32'h1);
    check({tag, "_done_id"}, 32'(bus.done_id), 32'(id));
    check_idle(tag);
  endtask

  logic [3:0] rr_seq [5];

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus.req     = '0;
    bus.limit_i = '0;
    #3;
    check_idle("rst");
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_done_id", 32'(bus.done_id), 32'h0);
    step();
    #2 rst_n = 1'b1;
    step();

    // 1: single request, limit 5
    set_lim(0, 4'd5);
    bus.req = 4'b0001;
    step();
    check("t1_grant", 32'(bus.grant), 32'h1);
    check("t1_busy",  32'(bus.busy),  32'h1);
    check("t1_count0", 32'(bus.count), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      step();
      check("t1_count", 32'(bus.count), 32'(k));
      check("t1_nodone", 32'(bus.done), 32'h0);
    end
    step();
    check_done("t1", 0);
    bus.req = '0;
    step();
    check("t1_pulse", 32'(bus.done), 32'h0);
    check_idle("t1_after");

    // 2: round robin across all requesters, limits 1
    do_reset();
    rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0100;
    rr_seq[3] = 4'b1000; rr_seq[4] = 4'b0001;
    for (int k = 0; k < 4; k++) set_lim(k, 4'd1);
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      step();
      check("t2_grant", 32'(bus.grant), 32'(rr_seq[g]));
      check("t2_count0", 32'(bus.count), 32'h0);
      step();
      check("t2_hold", 32'(bus.grant), 32'(rr_seq[g]));
      check("t2_count1", 32'(bus.count), 32'h1);
      step();
      check_done("t2", g % 4);
    end
    bus.req = '0;
    step();

    // 3: abort mid-run
    do_reset();
    set_lim(1, 4'd9);
    bus.req = 4'b0010;
    step();
    check("t3_grant", 32'(bus.grant), 32'h2);
    for (int k = 1; k <= 3; k++) step();
    check("t3_count3", 32'(bus.count), 32'h3);
    bus.req = '0;
    step();
    check_idle("t3_abort");
    check("t3_nodone", 32'(bus.done), 32'h0);
    step();
    check("t3_nodone2", 32'(bus.done), 32'h0);

    // 4: edge limits; limit_i changes after grant must be ignored
    do_reset();
    set_lim(0, 4'd0);
    bus.req = 4'b0001;
    step();
    check("t4a_grant", 32'(bus.grant), 32'h1);
    check("t4a_count", 32'(bus.count), 32'h0);
    step();
    check_done("t4a", 0);
    bus.req = '0;
    step();
    set_lim(2, 4'd15);
    bus.req = 4'b0100;
    step();
    check("t4b_grant", 32'(bus.grant), 32'h4);
    set_lim(2, 4'd3);
    for (int k = 1; k <= 15; k++) begin
      step();
      check("t4b_count", 32'(bus.count), 32'(k));
    end
    check("t4b_busy", 32'(bus.busy), 32'h1);
    step();
    check_done("t4b", 2);
    bus.req = '0;
    step();

    // 5: async reset mid-run, then priority restarts at requester 0
    do_reset();
    set_lim(0, 4'd9);
    set_lim(3, 4'd2);
    bus.req = 4'b0001;
    step();
    for (int k = 1; k <= 4; k++) step();
    check("t5_count4", 32'(bus.count), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check_idle("t5_async");
    bus.req = 4'b1001;
    #1 rst_n = 1'b1;
    step();
    check("t5_grant", 32'(bus.grant), 32'h1);
    bus.req = '0;
    step();
    check_idle("t5_abort");

    // 6: owner keeps requesting after done
    do_reset();
    set_lim(0, 4'd1);
    set_lim(1, 4'd1);
    bus.req = 4'b0011;
    step();
    check("t6_g0", 32'(bus.grant), 32'h1);
    step();
    step();
    check_done("t6_d0", 0);
    step();
    check("t6_g1", 32'(bus.grant), 32'h2);
    step();
    step();
    check_done("t6_d1", 1);
    step();
    check("t6_g0b", 32'(bus.grant), 32'h1);
    bus.req = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
